// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event pulses into fixed-width high windows
// separated by guaranteed low gaps, queueing events that arrive mid-window.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   in   : event input, each cycle sampled high is one event
//   out  : stretched output (registered)
//   busy : high whenever a window or gap is in progress (registered)
//   pend : number of queued events (registered)
//   drop : one-cycle pulse the cycle after an event is discarded
module pulse_stretcher #(
    parameter int HIGH_LEN = 4,
    parameter int GAP_LEN  = 1,
    parameter int PEND_MAX = 3,
    parameter int RETRIG   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in,
    output logic                            out,
    output logic                            busy,
    output logic [$clog2(PEND_MAX+1)-1:0]   pend,
    output logic                            drop
);
    localparam int PW   = $clog2(PEND_MAX + 1);
    localparam int CMAX = HIGH_LEN > GAP_LEN ? HIGH_LEN : GAP_LEN;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HIGH_LD = CW'(HIGH_LEN - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_LEN - 1);
    localparam logic [PW-1:0] PMAX    = PW'(PEND_MAX);

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [PW-1:0] pend_n;
    logic          drop_n;
    logic          cnt_z, retrig_hit, enq, deq, full, start;

    always_comb begin
        cnt_z      = cnt == '0;
        retrig_hit = (RETRIG != 0) && state == HIGH && in;
        // in GAP every event queues; in HIGH only when not retriggering
        enq        = in && (state == GAP || (state == HIGH && RETRIG == 0));
        // a new window leaves the gap if anything is queued or arrives on the exit edge
        deq        = state == GAP && cnt_z && (pend != '0 || in);
        full       = pend == PMAX;
        start      = (state == IDLE && in) || retrig_hit || deq;
        state_n    = state == IDLE ? (in ? HIGH : IDLE) :
                     state == HIGH ? ((cnt_z && !retrig_hit) ? GAP : HIGH) :
                     (cnt_z ? (deq ? HIGH : IDLE) : GAP);
        cnt_n      = start                          ? HIGH_LD :
                     (state == HIGH && cnt_z)       ? GAP_LD  :
                     (state == IDLE || cnt_z)       ? '0      : cnt - CW'(1);
        // simultaneous enq and deq cancel, so a full queue never drops in that case
        pend_n     = (enq && !deq && !full) ? pend + PW'(1) :
                     (deq && !enq)          ? pend - PW'(1) : pend;
        drop_n     = enq && !deq && full;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
            drop  <= drop_n;
        end
    end

    assign out  = state == HIGH;
    assign busy = state != IDLE;
endmodule
